// File: rtl/io_cfg_pkg.sv
// Shared types and helpers for the IO bank configuration sequencer.
// State codes are fixed localparams so legacy code can compare against raw values.
package io_cfg_pkg;

   localparam int STATE_W = 3;

   localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
   localparam logic [STATE_W-1:0] ST_SETUP = 3'd1;
   localparam logic [STATE_W-1:0] ST_PULSE = 3'd2;
   localparam logic [STATE_W-1:0] ST_HOLD  = 3'd3;
   localparam logic [STATE_W-1:0] ST_DONE  = 3'd4;

   typedef enum logic [STATE_W-1:0] {
      IDLE  = ST_IDLE,
      SETUP = ST_SETUP,
      PULSE = ST_PULSE,
      HOLD  = ST_HOLD,
      DONE  = ST_DONE
   } state_e;

   // Index width that stays at least one bit wide even for a single subtile.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/io_cfg_pulse_timer.sv
// Loadable down-counter timing the word-line pulse; expire flags terminal count 1.
module io_cfg_pulse_timer #(
   parameter int CNT_W = 2
) (
   input  logic             prog_clk,
   input  logic             prog_rst_n,
   input  logic             load,
   input  logic             dec,
   input  logic [CNT_W-1:0] value,
   output logic             expire
);

   logic [CNT_W-1:0] count_q;

   always_ff @(posedge prog_clk or negedge prog_rst_n) begin
      if (!prog_rst_n) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= value;
      end else if (dec && !expire) begin
         count_q <= count_q - CNT_W'(1);
      end
   end

   assign expire = (count_q == CNT_W'(1));

endmodule

// File: rtl/io_bank_cfg_sequencer.sv
// Programs the IO tile configuration bank one subtile at a time via bl/wl.
// Optional IO_CFG_SHADOW_EN adds shadow_q, a readback copy of programmed bits.
//
// state | meaning
// IDLE  | waiting for a request, cfg_ready high
// SETUP | bl[idx] presented (or idx skipped when unmasked)
// PULSE | wl[idx] high for WL_PULSE_CYCLES cycles
// HOLD  | wl released, bl[idx] still held
// DONE  | one-cycle completion pulse
module io_bank_cfg_sequencer
   import io_cfg_pkg::*;
#(
   parameter int NUM_IO          = 8,
   parameter int WL_PULSE_CYCLES = 2
) (
   input  logic              prog_clk,
   input  logic              prog_rst_n,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [NUM_IO-1:0] cfg_word,
   input  logic [NUM_IO-1:0] cfg_mask,
   output logic              busy,
   output logic              done,
   output logic [NUM_IO-1:0] bl,
   output logic [NUM_IO-1:0] wl
`ifdef IO_CFG_SHADOW_EN
   ,
   output logic [NUM_IO-1:0] shadow_q
`endif
);

   localparam int IDX_W = clog2_min1(NUM_IO);
   localparam int CNT_W = (WL_PULSE_CYCLES < 1) ? 1 : $clog2(WL_PULSE_CYCLES + 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_IO - 1);
   localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(WL_PULSE_CYCLES);

   if (WL_PULSE_CYCLES < 1) begin : g_bad_pulse
      $error("io_bank_cfg_sequencer: WL_PULSE_CYCLES must be >= 1");
   end
   if (NUM_IO < 1) begin : g_bad_num_io
      $error("io_bank_cfg_sequencer: NUM_IO must be >= 1");
   end

   state_e            state_q, state_nxt;
   logic [IDX_W-1:0]  idx_q, idx_nxt;
   logic [NUM_IO-1:0] word_q, word_nxt;
   logic [NUM_IO-1:0] mask_q, mask_nxt;
   logic [NUM_IO-1:0] bl_nxt, wl_nxt;
   logic              timer_load, timer_dec, timer_expire;

   io_cfg_pulse_timer #(
      .CNT_W (CNT_W)
   ) u_pulse_timer (
      .prog_clk   (prog_clk),
      .prog_rst_n (prog_rst_n),
      .load       (timer_load),
      .dec        (timer_dec),
      .value      (PULSE_LOAD),
      .expire     (timer_expire)
   );

   always_comb begin
      state_nxt  = state_q;
      idx_nxt    = idx_q;
      word_nxt   = word_q;
      mask_nxt   = mask_q;
      timer_load = 1'b0;
      timer_dec  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cfg_valid) begin
               word_nxt  = cfg_word;
               mask_nxt  = cfg_mask;
               idx_nxt   = '0;
               state_nxt = SETUP;
            end
         end
         SETUP: begin
            if (mask_q[idx_q]) begin
               timer_load = 1'b1;
               state_nxt  = PULSE;
            end else if (idx_q == IDX_LAST) begin
               state_nxt = DONE;
            end else begin
               idx_nxt = idx_q + IDX_W'(1);
            end
         end
         PULSE: begin
            timer_dec = 1'b1;
            if (timer_expire) begin
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (idx_q == IDX_LAST) begin
               state_nxt = DONE;
            end else begin
               idx_nxt   = idx_q + IDX_W'(1);
               state_nxt = SETUP;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state so the flops line up with the state they describe.
   always_comb begin
      bl_nxt = '0;
      wl_nxt = '0;
      for (int i = 0; i < NUM_IO; i++) begin
         if (idx_nxt == IDX_W'(i)) begin
            if (state_nxt == PULSE) begin
               wl_nxt[i] = 1'b1;
            end
            if ((state_nxt == SETUP && mask_nxt[i]) || state_nxt == PULSE || state_nxt == HOLD) begin
               bl_nxt[i] = word_nxt[i];
            end
         end
      end
   end

   always_ff @(posedge prog_clk or negedge prog_rst_n) begin
      if (!prog_rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         word_q  <= '0;
         mask_q  <= '0;
         bl      <= '0;
         wl      <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_nxt;
         idx_q   <= idx_nxt;
         word_q  <= word_nxt;
         mask_q  <= mask_nxt;
         bl      <= bl_nxt;
         wl      <= wl_nxt;
         busy    <= (state_nxt != IDLE);
         done    <= (state_nxt == DONE);
      end
   end

   assign cfg_ready = (state_q == IDLE);

`ifdef IO_CFG_SHADOW_EN
   always_ff @(posedge prog_clk or negedge prog_rst_n) begin
      if (!prog_rst_n) begin
         shadow_q <= '0;
      end else if (state_q == HOLD) begin
         shadow_q[idx_q] <= word_q[idx_q];
      end
   end
`endif

endmodule

// File: tb/tb_io_bank_cfg_sequencer.sv
// Bench for io_bank_cfg_sequencer: directed and random requests against a per-cycle trace model.
module tb_io_bank_cfg_sequencer;

   localparam int N = 8;
   localparam int P = 2;

   logic         prog_clk   = 1'b0;
   logic         prog_rst_n = 1'b0;
   logic         cfg_valid  = 1'b0;
   logic [N-1:0] cfg_word   = '0;
   logic [N-1:0] cfg_mask   = '0;
   logic         cfg_ready;
   logic         busy;
   logic         done;
   logic [N-1:0] bl;
   logic [N-1:0] wl;
`ifdef IO_CFG_SHADOW_EN
   logic [N-1:0] shadow_q;
   logic [N-1:0] sh_m = '0;
`endif

   int checks = 0;
   int passes = 0;
   bit started = 1'b0;
   logic done_prev = 1'b0;

   logic [N-1:0] q_bl[$];
   logic [N-1:0] q_wl[$];
   bit           q_done[$];

   io_bank_cfg_sequencer #(
      .NUM_IO          (N),
      .WL_PULSE_CYCLES (P)
   ) dut (
      .prog_clk   (prog_clk),
      .prog_rst_n (prog_rst_n),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_word   (cfg_word),
      .cfg_mask   (cfg_mask),
      .busy       (busy),
      .done       (done),
      .bl         (bl),
      .wl         (wl)
`ifdef IO_CFG_SHADOW_EN
      ,
      .shadow_q   (shadow_q)
`endif
   );

   always #5 prog_clk = ~prog_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) begin
         passes++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Invariants sampled every cycle outside reset.
   always @(negedge prog_clk) begin
      if (started && prog_rst_n) begin
         check("wl_onehot0", 32'($onehot0(wl)), 32'd1);
         check("ready_vs_busy", 32'(cfg_ready), 32'(!busy));
         if (done_prev) check("done_single", 32'(done), 32'd0);
      end
      done_prev = done && prog_rst_n;
   end

   // Expected cycle-by-cycle outputs for one request, straight from the per-bit timing rules.
   task automatic build_trace(input logic [N-1:0] w, input logic [N-1:0] m);
      logic [N-1:0] sel;
      logic [N-1:0] bit_v;
      q_bl.delete();
      q_wl.delete();
      q_done.delete();
      for (int i = 0; i < N; i++) begin
         sel   = N'(1) << i;
         bit_v = w[i] ? sel : '0;
         if (m[i]) begin
            q_bl.push_back(bit_v); q_wl.push_back('0); q_done.push_back(1'b0);
            for (int p = 0; p < P; p++) begin
               q_bl.push_back(bit_v); q_wl.push_back(sel); q_done.push_back(1'b0);
            end
            q_bl.push_back(bit_v); q_wl.push_back('0); q_done.push_back(1'b0);
         end else begin
            q_bl.push_back('0); q_wl.push_back('0); q_done.push_back(1'b0);
         end
      end
      q_bl.push_back('0); q_wl.push_back('0); q_done.push_back(1'b1);
   endtask

   task automatic run_req(input logic [N-1:0] w, input logic [N-1:0] m,
                          input bit hold_valid, input int exp_done_cycle);
      int len;
      int done_at;
      int exp_at;
      build_trace(w, m);
      len     = q_bl.size();
      exp_at  = (exp_done_cycle != 0) ? exp_done_cycle : len;
      done_at = 0;
      @(negedge prog_clk);
      check("ready_pre", 32'(cfg_ready), 32'd1);
      cfg_valid = 1'b1;
      cfg_word  = w;
      cfg_mask  = m;
      for (int k = 1; k <= len; k++) begin
         @(negedge prog_clk);
         if (!hold_valid) cfg_valid = 1'b0;
         cfg_word = N'($urandom);
         cfg_mask = N'($urandom);
         check($sformatf("bl_c%0d", k), 32'(bl), 32'(q_bl[k-1]));
         check($sformatf("wl_c%0d", k), 32'(wl), 32'(q_wl[k-1]));
         check($sformatf("done_c%0d", k), 32'(done), 32'(q_done[k-1]));
         check($sformatf("busy_c%0d", k), 32'(busy), 32'd1);
         if (done === 1'b1 && done_at == 0) done_at = k;
      end
      check("done_cycle", 32'(done_at), 32'(exp_at));
      @(negedge prog_clk);
      check("ready_post", 32'(cfg_ready), 32'd1);
      check("busy_post", 32'(busy), 32'd0);
      check("wl_post", 32'(wl), 32'd0);
      cfg_valid = 1'b0;
`ifdef IO_CFG_SHADOW_EN
      sh_m = (sh_m & ~m) | (w & m);
      check("shadow", 32'(shadow_q), 32'(sh_m));
`endif
   endtask

   initial begin
      logic [N-1:0] w;
      logic [N-1:0] m;

      repeat (2) @(negedge prog_clk);
      check("rst_bl", 32'(bl), 32'd0);
      check("rst_wl", 32'(wl), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
`ifdef IO_CFG_SHADOW_EN
      check("rst_shadow", 32'(shadow_q), 32'd0);
`endif
      prog_rst_n = 1'b1;
      started    = 1'b1;
      @(negedge prog_clk);
      check("ready_after_rst", 32'(cfg_ready), 32'd1);

      run_req(8'hA5, 8'hFF, 1'b0, 33);
      run_req(N'($urandom), 8'h00, 1'b0, 9);
      run_req(8'h01, 8'h01, 1'b1, 12);

      // Abort during the first PULSE cycle of idx 3 (cycle 14).
      @(negedge prog_clk);
      check("ready_pre_abort", 32'(cfg_ready), 32'd1);
      cfg_valid = 1'b1;
      cfg_word  = N'($urandom);
      cfg_mask  = 8'hFF;
      @(negedge prog_clk);
      cfg_valid = 1'b0;
      repeat (13) @(negedge prog_clk);
      check("wl_idx3_pulse", 32'(wl), 32'h08);
      #2 prog_rst_n = 1'b0;
      #1;
      check("abort_wl", 32'(wl), 32'd0);
      check("abort_bl", 32'(bl), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
`ifdef IO_CFG_SHADOW_EN
      sh_m = '0;
      check("abort_shadow", 32'(shadow_q), 32'd0);
`endif
      repeat (3) begin
         @(negedge prog_clk);
         check("abort_no_done", 32'(done), 32'd0);
      end
      prog_rst_n = 1'b1;
      run_req(N'($urandom), 8'hFF, 1'b0, 33);

`ifdef IO_CFG_SHADOW_EN
      run_req(8'hFF, 8'hFF, 1'b0, 33);
      run_req(8'h00, 8'h0F, 1'b0, 0);
      check("shadow_F0", 32'(shadow_q), 32'hF0);
`endif

      for (int r = 0; r < 12; r++) begin
         w = N'($urandom);
         case ($urandom_range(0, 5))
            0:       m = '0;
            1:       m = '1;
            default: m = N'($urandom);
         endcase
         run_req(w, m, 1'($urandom_range(0, 1)), 0);
      end

      repeat (2) @(negedge prog_clk);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
